// File: rtl/cpu_pkg.sv
// cpu_pkg: address-map constants and small shared types for the pipelined
// MIPS core.
// PC unit, CP0 and instruction memory import this package, so the reset
// vector, exception vector and legal fetch window are defined only once.
package cpu_pkg;

    localparam int          WIDTH_DEF        = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;
    localparam logic [31:0] ADDR_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] ADDR_HI_DEF      = 32'h0000_6FFC;
    localparam int          STEP_DEF         = 4;

    // RUN: no buffered redirect. HOLD: pend_q holds a redirect captured
    // during a stall.
    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HOLD = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_addr_check.sv
// pc_addr_check: combinational fetch/data address legality checker.
// Flags addresses that are not word aligned or that fall outside the
// inclusive window [ADDR_LO, ADDR_HI]. All comparisons are unsigned.
// Ports:
//   addr  in  WIDTH : address under test
//   adel  out 1     : 1 when addr is misaligned or out of range
module pc_addr_check
    import cpu_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] ADDR_LO = WIDTH'(ADDR_LO_DEF),
    parameter logic [WIDTH-1:0] ADDR_HI = WIDTH'(ADDR_HI_DEF)
) (
    input  logic [WIDTH-1:0] addr,
    output logic             adel
);

    logic misaligned;
    logic below;
    logic above;

    assign misaligned = (addr[1:0] != 2'b00);
    assign below      = (addr < ADDR_LO);
    assign above      = (addr > ADDR_HI);
    assign adel       = misaligned | below | above;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter at the head of the IF stage.
// Holds the fetch address and advances it by STEP. Accepts redirects from
// decode, stalls from the hazard unit, and exception entry / eret from CP0.
// A redirect that arrives while stalled is buffered in a one-entry pending
// slot and applied on the first unstalled edge, unless a newer live redirect
// or an exception/eret supersedes it.
// Ports:
//   i_clk        in  1     : clock, rising edge
//   i_reset      in  1     : synchronous active-high reset
//   i_stall      in  1     : hold PC this cycle
//   i_br_valid   in  1     : redirect request
//   i_br_target  in  WIDTH : redirect address
//   i_exc        in  1     : exception/interrupt entry (overrides stall)
//   i_eret       in  1     : return from exception (overrides stall)
//   i_epc        in  WIDTH : eret return address
//   o_PC         out WIDTH : current fetch address (registered)
//   o_PC_plus    out WIDTH : o_PC + STEP (combinational)
//   o_pend       out 1     : buffered redirect waiting (registered)
//   o_adel       out 1     : o_PC is an illegal fetch address (combinational)
module pc_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(STEP_DEF),
    parameter logic [WIDTH-1:0] ADDR_LO      = WIDTH'(ADDR_LO_DEF),
    parameter logic [WIDTH-1:0] ADDR_HI      = WIDTH'(ADDR_HI_DEF)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_br_valid,
    input  logic [WIDTH-1:0] i_br_target,
    input  logic             i_exc,
    input  logic             i_eret,
    input  logic [WIDTH-1:0] i_epc,
    output logic [WIDTH-1:0] o_PC,
    output logic [WIDTH-1:0] o_PC_plus,
    output logic             o_pend,
    output logic             o_adel
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] pc_seq;

    // Sequential address; wraps modulo 2^WIDTH by construction.
    assign pc_seq = pc_q + STEP;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= PC_RUN;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Priority: exc > eret > live redirect > pending > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;

        if (i_exc) begin
            pc_d    = EXC_VECTOR;
            pend_d  = '0;
            state_d = PC_RUN;
        end else if (i_eret) begin
            pc_d    = i_epc;
            pend_d  = '0;
            state_d = PC_RUN;
        end else begin
            case (state_q)
                PC_RUN: begin
                    if (!i_stall) begin
                        pc_d = i_br_valid ? i_br_target : pc_seq;
                    end else if (i_br_valid) begin
                        pend_d  = i_br_target;
                        state_d = PC_HOLD;
                    end
                end
                PC_HOLD: begin
                    if (i_stall) begin
                        // Newer redirect replaces the buffered one.
                        if (i_br_valid) pend_d = i_br_target;
                    end else begin
                        pc_d    = i_br_valid ? i_br_target : pend_q;
                        state_d = PC_RUN;
                    end
                end
                default: state_d = PC_RUN;
            endcase
        end
    end

    assign o_PC      = pc_q;
    assign o_PC_plus = pc_seq;
    assign o_pend    = (state_q == PC_HOLD);

    pc_addr_check #(
        .WIDTH   (WIDTH),
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI)
    ) u_addr_check (
        .addr (pc_q),
        .adel (o_adel)
    );

endmodule
